// File: rtl/i2cm_share_arb_if.sv
// Bundle between the requester blocks, the shared-core arbiter and the
// single lsc_i2cm_16 core.
//   slave  : arbiter side (receives requests, drives the core command)
//   master : environment side (requesters plus the I2C core)
// Request-side vectors are flattened per requester:
//   req_dev_addr[7*i +: 7], req_ofs_addr[16*i +: 16], req_wr_data[8*i +: 8].
interface i2cm_share_arb_if #(
  parameter int N_REQ = 3
);
  // requester side
  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    req_lock;
  logic [N_REQ-1:0]    req_rw;
  logic [7*N_REQ-1:0]  req_dev_addr;
  logic [16*N_REQ-1:0] req_ofs_addr;
  logic [8*N_REQ-1:0]  req_wr_data;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    req_done;
  logic                req_err;
  logic [7:0]          rd_data;
  // core side
  logic                core_run;
  logic                core_rw;
  logic [6:0]          core_dev_addr;
  logic [15:0]         core_ofs_addr;
  logic [7:0]          core_wr_data;
  logic                core_running;
  logic                core_done;
  logic [7:0]          core_rd_data;
  // status
  logic                busy;

  modport slave (
    input  req, req_lock, req_rw, req_dev_addr, req_ofs_addr, req_wr_data,
    input  core_running, core_done, core_rd_data,
    output gnt, req_done, req_err, rd_data,
    output core_run, core_rw, core_dev_addr, core_ofs_addr, core_wr_data,
    output busy
  );

  modport master (
    output req, req_lock, req_rw, req_dev_addr, req_ofs_addr, req_wr_data,
    output core_running, core_done, core_rd_data,
    input  gnt, req_done, req_err, rd_data,
    input  core_run, core_rw, core_dev_addr, core_ofs_addr, core_wr_data,
    input  busy
  );
endinterface

// File: rtl/i2cm_share_arb.sv
// Shares one 16-bit-offset I2C master core among N_REQ requesters.
// One register transaction per grant: IDLE picks a winner (round robin,
// with an optional burst lock), ISSUE pulses core_run, WAIT waits for
// core_done or a timeout, DONE returns req_done/req_err/rd_data.
// Ports:
//   clk    : system clock
//   reset  : synchronous, active-high
//   bus    : i2cm_share_arb_if.slave (requests, grants, core command/status)
module i2cm_share_arb #(
  parameter int          N_REQ        = 3,
  parameter logic [23:0] TIMEOUT_CYC  = 24'd4800000,
  parameter logic [6:0]  DEV_ADDR_DEF = 7'h24
) (
  input  logic            clk,
  input  logic            reset,
  i2cm_share_arb_if.slave bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]       state;
  logic [IDX_W-1:0] last;
  logic             lock_hold;
  logic [23:0]      wait_cnt;

  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] req_done;
  logic             req_err;
  logic [7:0]       rd_data;
  logic             core_run;
  logic             core_rw;
  logic [6:0]       core_dev_addr;
  logic [15:0]      core_ofs_addr;
  logic [7:0]       core_wr_data;

  logic [IDX_W:0]   cand;
  logic [IDX_W-1:0] rr_idx;
  logic [IDX_W-1:0] win;
  logic             win_rw;
  logic [6:0]       win_dev;
  logic [15:0]      win_ofs;
  logic [7:0]       win_wr;

  // Busy flag from the core is informational; sequencing relies on
  // core_done and the WAIT timeout.
  logic             core_running_unused;
  assign core_running_unused = bus.core_running;

  // Round-robin search starting at last+1. Offsets are scanned from the
  // farthest to the nearest so the nearest requesting index ends up in
  // rr_idx. Offset N_REQ wraps back to last itself (lowest priority).
  always_comb begin
    rr_idx = last;
    cand   = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = {1'b0, last} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N_REQ)) cand = cand - (IDX_W+1)'(N_REQ);
      if (bus.req[cand[IDX_W-1:0]]) rr_idx = cand[IDX_W-1:0];
    end
  end

  // A held burst lock keeps the previous owner in front while it still requests.
  assign win = (lock_hold && bus.req[last]) ? last : rr_idx;

  always_comb begin
    win_rw  = 1'b0;
    win_dev = '0;
    win_ofs = '0;
    win_wr  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == IDX_W'(i)) begin
        win_rw  = bus.req_rw[i];
        win_dev = bus.req_dev_addr[i*7 +: 7];
        win_ofs = bus.req_ofs_addr[i*16 +: 16];
        win_wr  = bus.req_wr_data[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      last          <= IDX_W'(N_REQ-1);
      lock_hold     <= 1'b0;
      wait_cnt      <= '0;
      gnt           <= '0;
      req_done      <= '0;
      req_err       <= 1'b0;
      rd_data       <= '0;
      core_run      <= 1'b0;
      core_rw       <= 1'b0;
      core_dev_addr <= '0;
      core_ofs_addr <= '0;
      core_wr_data  <= '0;
    end else begin
      core_run <= 1'b0;
      req_done <= '0;
      req_err  <= 1'b0;
      case (state)
        // grant boundary: command is captured here and never re-read
        IDLE: begin
          if (!bus.req[last]) lock_hold <= 1'b0;
          if (|bus.req) begin
            core_rw       <= win_rw;
            core_dev_addr <= (win_dev == 7'd0) ? DEV_ADDR_DEF : win_dev;
            core_ofs_addr <= win_ofs;
            core_wr_data  <= win_wr;
            gnt           <= N_REQ'(1) << win;
            last          <= win;
            core_run      <= 1'b1;
            state         <= ISSUE;
          end
        end
        // core_run is high throughout this single cycle
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        // completion boundary: core_done takes precedence over the timeout
        WAIT: begin
          if (bus.core_done) begin
            rd_data  <= bus.core_rd_data;
            req_done <= gnt;
            state    <= DONE;
          end else if (wait_cnt == TIMEOUT_CYC - 24'd1) begin
            req_done <= gnt;
            req_err  <= 1'b1;
            state    <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 24'd1;
          end
        end
        // release boundary: lock request sampled while req_done is visible
        default: begin
          lock_hold <= bus.req_lock[last];
          gnt       <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt           = gnt;
  assign bus.req_done      = req_done;
  assign bus.req_err       = req_err;
  assign bus.rd_data       = rd_data;
  assign bus.core_run      = core_run;
  assign bus.core_rw       = core_rw;
  assign bus.core_dev_addr = core_dev_addr;
  assign bus.core_ofs_addr = core_ofs_addr;
  assign bus.core_wr_data  = core_wr_data;
  assign bus.busy          = (state != IDLE);

endmodule

// File: doc/i2cm_share_arb.md
Name: i2cm_share_arb

Overview:
- Arbiter and sequencer that shares one 16-bit-offset I2C master core (`lsc_i2cm_16`) among several requesters.
- Typical requesters: the sensor init ROM sequencer, a runtime exposure/gain writer and a status-register reader.
- Accepts one register transaction per grant, issues it to the core, waits for completion and returns done/read data/error to the winner.
- Sits between the requester blocks and the single core instance that drives the camera's SCL/SDA.

Parameters:
- `N_REQ`, 3, number of requesters (2..4).
- `TIMEOUT_CYC`, 24'd4800000, WAIT-state cycle limit before the transaction is aborted (100 ms at 48 MHz).
- `DEV_ADDR_DEF`, 7'h24, device address used when a requester drives `req_dev_addr` = 0.

Ports:
- `clk`  in  1  system clock (48 MHz).
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  N_REQ  per-requester transaction request, level.
- `req_lock`  in  N_REQ  requester asks to keep priority for its next request (burst).
- `req_rw`  in  N_REQ  per-requester direction: 1 = read, 0 = write.
- `req_dev_addr`  in  7*N_REQ  per-requester 7-bit device address; 0 selects `DEV_ADDR_DEF`.
- `req_ofs_addr`  in  16*N_REQ  per-requester register offset.
- `req_wr_data`  in  8*N_REQ  per-requester write byte.
- `gnt`  out  N_REQ  one-hot; the requester owning the core.
- `req_done`  out  N_REQ  one-cycle completion pulse to the owner.
- `req_err`  out  1  qualifies `req_done`: 1 = timeout abort.
- `rd_data`  out  8  read byte, valid when `req_done` pulses.
- `core_run`  out  1  one-cycle start pulse to the core.
- `core_rw`, `core_dev_addr`(7), `core_ofs_addr`(16), `core_wr_data`(8)  out  latched command to the core.
- `core_running`  in  1  core busy.
- `core_done`  in  1  core completion pulse.
- `core_rd_data`  in  8  core read byte.
- `busy`  out  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - State = IDLE.
  - `gnt`, `req_done`, `req_err`, `core_run`, `busy` = 0.
  - `rd_data` and all `core_*` command regs = 0.
  - Round-robin pointer `last` = N_REQ-1.
  - `lock_hold` = 0.
- States: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE:
  - If any `req` bit is set, select the winner.
    - If `lock_hold` is set and `req[last]` is high, `last` wins.
    - Otherwise the first set bit searching upward from `last`+1, with modulo wrap.
  - In the same edge: latch the winner's rw/dev_addr/ofs_addr/wr_data into the `core_*` regs, substituting `DEV_ADDR_DEF` when dev_addr = 0.
  - Also in the same edge: set `gnt` one-hot, set `last` = winner, go to ISSUE.
  - Grant latency: 1 cycle from `req` high to `gnt` high.
- ISSUE: `core_run` = 1 for exactly this cycle; go to WAIT.
- WAIT:
  - On `core_done`: capture `core_rd_data` into `rd_data`, go to DONE with err = 0.
  - If the cycle counter reaches `TIMEOUT_CYC`-1 without `core_done`: go to DONE with err = 1 and leave `rd_data` unchanged.
  - The counter clears on entry to WAIT.
  - If `core_done` and timeout occur in the same cycle, `core_done` wins (err = 0).
- DONE:
  - Pulse `req_done[winner]` = 1 and drive `req_err` for one cycle.
  - Set `lock_hold` = `req_lock[winner]`, sampled this cycle.
  - Clear `gnt` at the next edge and return to IDLE.
  - Winner-to-next-grant gap: min 2 cycles (DONE, IDLE).
- Request rules:
  - A requester holds `req` until its `req_done` pulse.
  - Command inputs are sampled only at grant; changes after grant are ignored.
  - Deasserting `req` before grant withdraws the request.
  - Deasserting after grant does not abort; `req_done` still pulses.
  - A requester must drop `req` or present a new command on the cycle after `req_done`.
    - IDLE re-evaluates on the following edge, so a held `req` is treated as a new transaction.
- Lock rules:
  - `lock_hold` lets one requester (e.g. the 80-command init sequencer) run a burst without interleaving.
  - `lock_hold` is released when the locked requester's `req` is low in IDLE or its `req_lock` is low at DONE.
- `core_running` is informational only; sequencing uses `core_done` and the timeout.
- Reset mid-transaction: everything returns to reset values at the next edge.
  - `core_run` is not re-issued.
  - No `req_done` pulses for the aborted transaction.
- `busy` = (state != IDLE).

Test Plan:
- Single write: `req[0]`, ofs=16'h0103, wr=8'h00, dev=0.
  - `gnt`=3'b001 after 1 cycle.
  - `core_run` pulse with `core_dev_addr`=7'h24 and `core_ofs_addr`=16'h0103.
  - `core_done` after 50 cycles -> `req_done[0]` 1 cycle later, `req_err`=0.
- Read:
  - `req[2]`, rw=1, ofs=16'h0000, core returns 8'h01 -> `rd_data`=8'h01 during `req_done[2]`.
- Round robin:
  - `req`=3'b111 continuously from reset.
  - Grant order 2? no: 0,1,2,0 (`last` starts at 2); never two consecutive grants to the same requester.
- Lock burst:
  - `req[0]` + `req_lock[0]` held for 5 transactions while `req[1]` is high.
  - Five consecutive grants to 0; `req[1]` granted only after `req_lock[0]` drops.
- Timeout: `core_done` never asserted.
  - `req_done` with `req_err`=1 exactly `TIMEOUT_CYC` cycles after WAIT entry (use `TIMEOUT_CYC`=100 in the bench).
  - Next requester is granted afterwards.
- Reset in WAIT:
  - `reset` pulsed for 1 cycle -> `gnt`=0, `busy`=0, no `req_done`.
  - Held `req` is re-granted 1 cycle after reset release.
